// File: rtl/filter_sched.sv
// Purpose: turns debounced select buttons (with a 4-button GRAYSCALE chord) into a filter code committed only at the frame-boundary pixel.
// Latency: filter_pending one cycle after a select rise; filter updates on the clock edge that samples the commit point.
// Backpressure: none; later presses restart collection, filters_en low drops any request. Optional auto-cycle: define FILTER_SCHED_AUTO_EN.
module filter_sched #(
    parameter int CHORD_WIN   = 4096,
    parameter int H_COMMIT    = 0,
    parameter int V_COMMIT    = 768,
    parameter int AUTO_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        filters_en,
    input  logic        filters_user_in_en,
    input  logic [3:0]  select,
    input  logic        auto_en,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [2:0]  filter,
    output logic        filter_pending,
    output logic        commit_pulse
);
    // Shared filter encodings; the auto-cycle order is simply code + 1, wrapping after CARTOON.
    localparam logic [2:0] F_GRAY    = 3'd0;
    localparam logic [2:0] F_SEPIA   = 3'd1;
    localparam logic [2:0] F_INVERT  = 3'd2;
    localparam logic [2:0] F_EDGE    = 3'd3;
    localparam logic [2:0] F_CARTOON = 3'd4;

    localparam int CW = $clog2(CHORD_WIN + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, PENDING} state_t;

    state_t      state, state_nxt;
    logic [3:0]  select_q, rise, mask, mask_nxt;
    logic [CW-1:0] win_cnt, win_cnt_nxt;
    logic [2:0]  request, request_nxt, filter_user, filter_nxt;
    logic        commit_pt, new_press, user_commit, auto_step;

    // Full chord wins; otherwise the highest-numbered button pressed in the window.
    function automatic logic [2:0] resolve(input logic [3:0] m);
        if (m == 4'hF)   return F_GRAY;
        else if (m[3])   return F_CARTOON;
        else if (m[2])   return F_EDGE;
        else if (m[1])   return F_INVERT;
        else             return F_SEPIA;
    endfunction

    assign commit_pt = (hcount == 11'(H_COMMIT)) && (vcount == 10'(V_COMMIT));
    assign rise      = select & ~select_q;
    assign new_press = (|rise) && filters_user_in_en;

    // Request state machine: collect a chord window, then hold the request until the commit point.
    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        win_cnt_nxt = win_cnt;
        request_nxt = request;
        filter_user = filter;
        user_commit = 1'b0;
        if (!filters_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (new_press) begin
                        state_nxt   = COLLECT;
                        mask_nxt    = select;
                        win_cnt_nxt = '0;
                    end
                end
                COLLECT: begin
                    mask_nxt    = mask | select;
                    win_cnt_nxt = win_cnt + 1'b1;
                    if (win_cnt == CW'(CHORD_WIN - 1)) begin
                        request_nxt = resolve(mask | select);
                        state_nxt   = PENDING;
                    end
                end
                PENDING: begin
                    if (commit_pt) begin
                        filter_user = request;
                        user_commit = 1'b1;
                        state_nxt   = IDLE;
                    end
                    // A fresh press restarts collection; on a commit cycle it starts the next request.
                    if (new_press) begin
                        state_nxt   = COLLECT;
                        mask_nxt    = select;
                        win_cnt_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef FILTER_SCHED_AUTO_EN
    localparam int AW = $clog2(AUTO_FRAMES + 1);
    logic [AW-1:0] auto_cnt, auto_cnt_nxt;

    // Auto counter: counts idle commit points, cleared by any user commit.
    always_comb begin
        auto_cnt_nxt = auto_cnt;
        auto_step    = 1'b0;
        if (filters_en && auto_en && state == IDLE && commit_pt) begin
            if (auto_cnt == AW'(AUTO_FRAMES - 1)) begin
                auto_cnt_nxt = '0;
                auto_step    = 1'b1;
            end else begin
                auto_cnt_nxt = auto_cnt + 1'b1;
            end
        end else if (user_commit) begin
            auto_cnt_nxt = '0;
        end
    end

    // Auto counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) auto_cnt <= '0;
        else        auto_cnt <= auto_cnt_nxt;
    end
`else
    logic auto_unused;
    assign auto_unused = auto_en;
    assign auto_step   = 1'b0;
`endif

    // Final filter selection: user commit and auto step never coincide (they need different states).
    always_comb begin
        filter_nxt = filter_user;
        if (auto_step) filter_nxt = (filter == F_CARTOON) ? F_GRAY : filter + 3'd1;
    end

    assign commit_pulse   = (filter_nxt != filter);
    assign filter_pending = (state != IDLE);

    // State, edge-detect and committed filter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            select_q <= '0;
            mask     <= '0;
            win_cnt  <= '0;
            request  <= F_GRAY;
            filter   <= F_GRAY;
        end else begin
            state    <= state_nxt;
            select_q <= select;
            mask     <= mask_nxt;
            win_cnt  <= win_cnt_nxt;
            request  <= request_nxt;
            filter   <= filter_nxt;
        end
    end
endmodule
